// File: rtl/rf68000_nic_pkg.sv
// Shared types for the rf68000 ring NIC: packet layout, packet types and the bus-side FSM states.
package rf68000_nic_pkg;

    localparam int         PKT_W    = 84;
    localparam logic [3:0] BCAST_ID = 4'hF;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        WR   = 4'd1,
        RD   = 4'd2,
        RACK = 4'd3
    } pkt_typ_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_REL,
        ST_RESP
    } nic_state_t;

    typedef struct packed {
        pkt_typ_t    typ;
        logic [3:0]  did;
        logic [3:0]  sid;
        logic [3:0]  age;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;

endpackage

// File: rtl/rf68000_nic_slot_mux.sv
// Classifies the incoming ring slot (consume/capture/drop/forward) and picks the outgoing packet.
// RF68000_NIC_BROADCAST_EN adds local execution plus forwarding of WR packets sent to BCAST_ID.
module rf68000_nic_slot_mux
    import rf68000_nic_pkg::*;
#(
    parameter logic [3:0] MAX_AGE = 4'd15
) (
    input  logic [3:0] i_id,
    input  packet_t    i_pkt,
    input  logic       i_idle,
    input  logic       i_rx_full,
    input  logic       i_resp_rdy,
    input  packet_t    i_resp_pkt,
    input  logic       i_tx_req,
    input  packet_t    i_tx_pkt,
    output logic       o_consume,
    output logic       o_capture,
    output logic       o_drop,
    output logic       o_resp_take,
    output logic       o_tx_take,
    output packet_t    o_pkt
);

    logic w_is_req;
    logic w_here;
    logic w_fwd;

    always_comb begin
        w_is_req  = (i_pkt.typ == WR) || (i_pkt.typ == RD);
        w_here    = (i_pkt.did == i_id);
        o_consume = 1'b0;
        o_capture = 1'b0;
        o_drop    = 1'b0;
        w_fwd     = 1'b0;
        if (i_pkt.typ != NOP) begin
`ifdef RF68000_NIC_BROADCAST_EN
            // A broadcast is retired silently once it has travelled back to its sender.
            if ((i_pkt.typ == WR) && (i_pkt.did == BCAST_ID)) begin
                if (i_pkt.sid != i_id) begin
                    o_consume = i_idle;
                    if (i_pkt.age == MAX_AGE) o_drop = 1'b1;
                    else                      w_fwd  = 1'b1;
                end
            end else
`endif
            if (w_is_req && w_here && i_idle)
                o_consume = 1'b1;
            else if ((i_pkt.typ == RACK) && w_here && !i_rx_full)
                o_capture = 1'b1;
            else if ((i_pkt.age == MAX_AGE) || ((i_pkt.sid == i_id) && (i_pkt.typ != RACK)))
                o_drop = 1'b1;
            else
                w_fwd = 1'b1;
        end
    end

    always_comb begin
        o_pkt       = '0;
        o_resp_take = 1'b0;
        o_tx_take   = 1'b0;
        if (w_fwd) begin
            o_pkt     = i_pkt;
            o_pkt.age = i_pkt.age + 4'd1;
        end else if (i_resp_rdy) begin
            o_pkt       = i_resp_pkt;
            o_resp_take = 1'b1;
        end else if (i_tx_req) begin
            o_pkt     = i_tx_pkt;
            o_pkt.age = '0;
            o_tx_take = 1'b1;
        end
    end

endmodule

// File: rtl/rf68000_ring_nic.sv
// Per-node ring NIC: executes packets addressed here as bus cycles, returns read data, injects tx, captures rx.
// Optional broadcast writes are enabled with RF68000_NIC_BROADCAST_EN (see rf68000_nic_slot_mux).
module rf68000_ring_nic
    import rf68000_nic_pkg::*;
#(
    parameter logic [3:0] MAX_AGE = 4'd15,
    parameter logic [7:0] ACK_TMO = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  id,
    input  packet_t     packet_i,
    output packet_t     packet_o,
    output logic        nic_cyc,
    output logic        nic_stb,
    output logic        nic_we,
    output logic [3:0]  nic_sel,
    output logic [31:0] nic_adr,
    output logic [31:0] nic_dato,
    input  logic [31:0] nic_dati,
    input  logic        nic_ack,
    input  logic        tx_req,
    input  packet_t     tx_pkt,
    output logic        tx_ack,
    output logic        rx_valid,
    output packet_t     rx_pkt,
    input  logic        rx_ack,
    output logic [7:0]  drop_cnt
);

    nic_state_t  r_state;
    logic [7:0]  r_wdog;
    logic        r_req_rd;
    logic [3:0]  r_req_sid;
    logic        r_resp_vld;
    packet_t     r_resp_pkt;
    packet_t     r_pkt_o;
    logic        r_tx_ack;
    logic        r_rx_valid;
    packet_t     r_rx_pkt;
    logic [7:0]  r_drop_cnt;
    logic        r_nic_cyc;
    logic        r_nic_stb;
    logic        r_nic_we;
    logic [3:0]  r_nic_sel;
    logic [31:0] r_nic_adr;
    logic [31:0] r_nic_dato;

    logic        w_consume;
    logic        w_capture;
    logic        w_drop;
    logic        w_resp_take;
    logic        w_tx_take;
    packet_t     w_slot_pkt;
    packet_t     w_resp;
    logic [7:0]  w_wdog_nxt;
    logic        w_bus_end;

    rf68000_nic_slot_mux #(.MAX_AGE(MAX_AGE)) u_slot_mux (
        .i_id        (id),
        .i_pkt       (packet_i),
        .i_idle      (r_state == ST_IDLE),
        .i_rx_full   (r_rx_valid),
        .i_resp_rdy  ((r_state == ST_RESP) && r_resp_vld),
        .i_resp_pkt  (r_resp_pkt),
        .i_tx_req    (tx_req),
        .i_tx_pkt    (tx_pkt),
        .o_consume   (w_consume),
        .o_capture   (w_capture),
        .o_drop      (w_drop),
        .o_resp_take (w_resp_take),
        .o_tx_take   (w_tx_take),
        .o_pkt       (w_slot_pkt)
    );

    assign w_wdog_nxt = r_wdog + 8'd1;
    assign w_bus_end  = (r_state == ST_BUS) && (nic_ack || (w_wdog_nxt == ACK_TMO));

    // A timed-out read still answers, with a recognisable poison word instead of data.
    always_comb begin
        w_resp     = '0;
        w_resp.typ = RACK;
        w_resp.did = r_req_sid;
        w_resp.sid = id;
        w_resp.sel = r_nic_sel;
        w_resp.adr = r_nic_adr;
        w_resp.dat = nic_ack ? nic_dati : 32'hDEAD_DEAD;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_wdog     <= '0;
            r_req_rd   <= 1'b0;
            r_req_sid  <= '0;
            r_resp_vld <= 1'b0;
            r_resp_pkt <= '0;
            r_pkt_o    <= '0;
            r_tx_ack   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_pkt   <= '0;
            r_drop_cnt <= '0;
            r_nic_cyc  <= 1'b0;
            r_nic_stb  <= 1'b0;
            r_nic_we   <= 1'b0;
            r_nic_sel  <= '0;
            r_nic_adr  <= '0;
            r_nic_dato <= '0;
        end else begin
            r_pkt_o  <= w_slot_pkt;
            r_tx_ack <= w_tx_take;
            if (w_drop && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_capture) begin
                r_rx_pkt   <= packet_i;
                r_rx_valid <= 1'b1;
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_consume) begin
                        r_nic_cyc  <= 1'b1;
                        r_nic_stb  <= 1'b1;
                        r_nic_we   <= (packet_i.typ == WR);
                        r_nic_sel  <= packet_i.sel;
                        r_nic_adr  <= packet_i.adr;
                        r_nic_dato <= packet_i.dat;
                        r_req_rd   <= (packet_i.typ == RD);
                        r_req_sid  <= packet_i.sid;
                        r_wdog     <= '0;
                        r_state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    r_wdog <= w_wdog_nxt;
                    if (w_bus_end) begin
                        r_nic_cyc <= 1'b0;
                        r_nic_stb <= 1'b0;
                        r_nic_we  <= 1'b0;
                        r_nic_sel <= '0;
                        if (r_req_rd) begin
                            r_resp_vld <= 1'b1;
                            r_resp_pkt <= w_resp;
                        end
                        r_state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!nic_ack)
                        r_state <= r_resp_vld ? ST_RESP : ST_IDLE;
                end
                ST_RESP: begin
                    if (w_resp_take) begin
                        r_resp_vld <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign packet_o = r_pkt_o;
    assign tx_ack   = r_tx_ack;
    assign rx_valid = r_rx_valid;
    assign rx_pkt   = r_rx_pkt;
    assign drop_cnt = r_drop_cnt;
    assign nic_cyc  = r_nic_cyc;
    assign nic_stb  = r_nic_stb;
    assign nic_we   = r_nic_we;
    assign nic_sel  = r_nic_sel;
    assign nic_adr  = r_nic_adr;
    assign nic_dato = r_nic_dato;

endmodule

// File: tb/tb_rf68000_ring_nic.sv
// Self-checking bench for rf68000_ring_nic: table of slot vectors plus multi-cycle bus/tx/rx/reset sequences.
module tb_rf68000_ring_nic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id;
    logic [83:0] pin;
    logic [83:0] pout;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dato, dati;
    logic        ack;
    logic        tx_req;
    logic [83:0] tx_pkt;
    logic        tx_ack;
    logic        rx_valid;
    logic [83:0] rx_pkt;
    logic        rx_ack;
    logic [7:0]  drops;

    int n_chk = 0;
    int n_err = 0;
    logic [83:0] exp_q[$];

    typedef struct {
        logic [83:0] pin;
        logic [83:0] pout;
        logic [7:0]  drops;
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    rf68000_ring_nic dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .id       (id),
        .packet_i (pin),
        .packet_o (pout),
        .nic_cyc  (cyc),
        .nic_stb  (stb),
        .nic_we   (we),
        .nic_sel  (sel),
        .nic_adr  (adr),
        .nic_dato (dato),
        .nic_dati (dati),
        .nic_ack  (ack),
        .tx_req   (tx_req),
        .tx_pkt   (tx_pkt),
        .tx_ack   (tx_ack),
        .rx_valid (rx_valid),
        .rx_pkt   (rx_pkt),
        .rx_ack   (rx_ack),
        .drop_cnt (drops)
    );

    function automatic logic [83:0] mk(input logic [3:0] typ, input logic [3:0] did,
                                       input logic [3:0] sid, input logic [3:0] age,
                                       input logic [3:0] s, input logic [31:0] a,
                                       input logic [31:0] d);
        return {typ, did, sid, age, s, a, d};
    endfunction

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [83:0] p, input logic [83:0] e, input string nm);
        pin = p;
        exp_q.push_back(e);
        tick();
        chk(nm, pout, exp_q.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pin   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input logic [83:0] e, input string nm);
        logic seen;
        seen = 1'b0;
        pin  = '0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (pout != '0) seen = 1'b1;
        end
        chk(nm, pout, e);
    endtask

    initial begin
        int n;

        vt[0] = '{mk(0,0,0,0,0,0,0),                   mk(0,0,0,0,0,0,0),                   8'd0};
        vt[1] = '{mk(1,3,5,2,4'hF,32'h100,32'hA),      mk(1,3,5,3,4'hF,32'h100,32'hA),      8'd0};
        vt[2] = '{mk(2,7,1,0,4'h1,32'h200,32'hB),      mk(2,7,1,1,4'h1,32'h200,32'hB),      8'd0};
        vt[3] = '{mk(3,4,0,6,4'h3,32'h300,32'hC),      mk(3,4,0,7,4'h3,32'h300,32'hC),      8'd0};
        vt[4] = '{mk(1,3,0,1,4'hF,32'h400,32'hD),      mk(0,0,0,0,0,0,0),                   8'd1};
        vt[5] = '{mk(2,9,4,15,4'hF,32'h500,32'hE),     mk(0,0,0,0,0,0,0),                   8'd2};
        vt[6] = '{mk(3,2,3,15,4'h1,32'h600,32'hF),     mk(0,0,0,0,0,0,0),                   8'd3};
        vt[7] = '{mk(1,6,1,14,4'h2,32'h700,32'h10),    mk(1,6,1,15,4'h2,32'h700,32'h10),    8'd3};

        id = 4'h0; dati = '0; ack = 1'b0; rx_ack = 1'b0;
        tx_req = 1'b1; tx_pkt = mk(1,5,0,3,4'hF,32'h0,32'h1);
        rst_n = 1'b0; pin = mk(1,3,5,2,4'hF,32'h100,32'hA);
        tick();
        chk("rst_pkt_o", pout, '0);
        chk("rst_cyc", cyc, 0);
        chk("rst_tx_ack", tx_ack, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_drops", drops, 0);
        tx_req = 1'b0;
        rst_n  = 1'b1;

        // Single-slot classification table.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].pin, vt[i].pout, $sformatf("vec%0d_out", i));
            chk($sformatf("vec%0d_drops", i), drops, vt[i].drops);
        end

        // Local write; a request arriving while busy is forwarded.
        do_reset();
        drive(mk(1,0,3,0,4'hF,32'hFFF0_0010,32'h1234_5678), '0, "wr_slot");
        chk("wr_cyc", cyc, 1);
        chk("wr_stb", stb, 1);
        chk("wr_we", we, 1);
        chk("wr_sel", sel, 4'hF);
        chk("wr_adr", adr, 32'hFFF0_0010);
        chk("wr_dato", dato, 32'h1234_5678);
        drive('0, '0, "wr_idle1");
        drive(mk(2,0,2,4,4'h1,32'h44,32'h0), mk(2,0,2,5,4'h1,32'h44,32'h0), "busy_fwd");
        chk("wr_cyc_hold", cyc, 1);
        ack = 1'b1;
        drive('0, '0, "wr_ack_slot");
        chk("wr_cyc_drop", cyc, 0);
        chk("wr_stb_drop", stb, 0);
        ack = 1'b0;
        for (int i = 0; i < 3; i++) drive('0, '0, "wr_no_resp");

        // Local read returns a response packet.
        drive(mk(2,0,2,1,4'h3,32'hFFF0_0020,32'h0), '0, "rd_slot");
        chk("rd_cyc", cyc, 1);
        chk("rd_we", we, 0);
        chk("rd_sel", sel, 4'h3);
        pin = '0; dati = 32'hCAFE_BABE; ack = 1'b1;
        tick();
        chk("rd_cyc_drop", cyc, 0);
        ack = 1'b0; dati = '0;
        wait_resp(mk(3,2,0,0,4'h3,32'hFFF0_0020,32'hCAFE_BABE), "rd_resp");

        // tx waits for a free slot.
        do_reset();
        tx_pkt = mk(1,5,0,9,4'hF,32'hA0,32'h55);
        tx_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(mk(2,7,3,i,4'h1,i,i), mk(2,7,3,i+1,4'h1,i,i), "tx_stream_fwd");
            chk("tx_ack_blocked", tx_ack, 0);
        end
        drive('0, mk(1,5,0,0,4'hF,32'hA0,32'h55), "tx_inject");
        chk("tx_ack_pulse", tx_ack, 1);
        tx_req = 1'b0;
        drive('0, '0, "tx_after");
        chk("tx_ack_low", tx_ack, 0);

        // Bus watchdog on an unanswered read.
        drive(mk(2,0,6,0,4'hF,32'h1000,32'h0), '0, "tmo_slot");
        pin = '0;
        n = 0;
        while (cyc && n < 400) begin
            n++;
            tick();
        end
        chk("tmo_len", n, 255);
        wait_resp(mk(3,6,0,0,4'hF,32'h1000,32'hDEAD_DEAD), "tmo_resp");

        // rx capture, forward when full, pop, and capture winning over pop.
        do_reset();
        drive(mk(3,0,4,2,4'h1,32'h10,32'h1111), '0, "rack1_slot");
        chk("rack1_valid", rx_valid, 1);
        chk("rack1_pkt", rx_pkt, mk(3,0,4,2,4'h1,32'h10,32'h1111));
        drive(mk(3,0,5,3,4'h2,32'h20,32'h2222), mk(3,0,5,4,4'h2,32'h20,32'h2222), "rack2_fwd");
        chk("rack2_keep", rx_pkt, mk(3,0,4,2,4'h1,32'h10,32'h1111));
        rx_ack = 1'b1;
        drive('0, '0, "rx_pop_slot");
        chk("rx_pop", rx_valid, 0);
        drive(mk(3,0,7,1,4'h4,32'h30,32'h3333), '0, "rack3_slot");
        chk("rack3_valid", rx_valid, 1);
        chk("rack3_pkt", rx_pkt, mk(3,0,7,1,4'h4,32'h30,32'h3333));
        rx_ack = 1'b0;

        // Reset in the middle of a bus cycle.
        drive(mk(2,0,2,0,4'hF,32'h50,32'h0), '0, "rst_bus_slot");
        chk("rst_bus_cyc", cyc, 1);
        rst_n = 1'b0; pin = mk(1,3,5,2,4'hF,32'h100,32'hA);
        tick();
        rst_n = 1'b1;
        chk("rst_bus_cyc_low", cyc, 0);
        chk("rst_bus_rx", rx_valid, 0);
        chk("rst_bus_pkt", pout, '0);

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) begin
            pin = mk(1,3,5,15,4'hF,i,i);
            tick();
        end
        chk("drop_sat", drops, 8'hFF);
        chk("drop_slot", pout, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rf68000_ring_nic.md
Name: rf68000_ring_nic

Overview:
- Per-node ring network interface; the bus master on the node arbiter's nic_* port.
- Receives fixed-format packets from the inter-node ring. Executes read/write packets addressed to this node as local bus cycles. Returns read data as response packets.
- Injects locally originated request packets (tx) and delivers response packets addressed to this node (rx).
- Forwards everything else one hop with a registered output.

Parameters:
- PKT_W, 84, packet width.
- MAX_AGE, 4'd15, hop count at which a forwarded packet is dropped.
- ACK_TMO, 8'd255, bus-cycle watchdog limit in clocks.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- id  in  4  node id.
- packet_i  in  PKT_W  ring input; a slot is empty when typ==NOP.
- packet_o  out  PKT_W  ring output, registered.
- nic_cyc  out  1  bus cycle.
- nic_stb  out  1  bus strobe.
- nic_we  out  1  bus write enable.
- nic_sel  out  4  byte lane selects.
- nic_adr  out  32  bus address.
- nic_dato  out  32  write data.
- nic_dati  in  32  read data.
- nic_ack  in  1  bus acknowledge.
- tx_req  in  1  local request pending.
- tx_pkt  in  PKT_W  packet to inject.
- tx_ack  out  1  one-cycle pulse: tx_pkt taken.
- rx_valid  out  1  rx_pkt holds an undelivered response.
- rx_pkt  out  PKT_W  captured response.
- rx_ack  in  1  consumer pops rx.
- drop_cnt  out  8  saturating dropped-packet count.

Behaviour:
- Packet fields, MSB→LSB: typ[3:0], did[3:0], sid[3:0], age[3:0], sel[3:0], adr[31:0], dat[31:0]. Write enable is implied by typ.
- typ values: NOP=0, WR=1, RD=2, RACK=3.
- Reset (rst_ni==0 at an edge) clears all of: packet_o (NOP, all fields 0), nic_cyc, nic_stb, nic_we, nic_sel, nic_adr, nic_dato, tx_ack, rx_valid, rx_pkt, drop_cnt, and the response buffer; state←ST_IDLE. Reset mid-cycle drops nic_cyc on that edge.
- Consume rule: an incoming WR/RD with did==id is consumed only if state==ST_IDLE. On that edge:
  - nic_cyc=nic_stb=1; nic_we=(typ==WR); nic_sel=sel; nic_adr=adr; nic_dato=dat.
  - state←ST_BUS; watchdog←0.
- Otherwise the incoming WR/RD is forwarded.
- ST_BUS:
  - On nic_ack: cyc, stb, we and sel drop. For RD, load the response buffer with {RACK, did=sid_in, sid=id, age=0, sel, adr, nic_dati}. state←ST_REL.
  - Watchdog reaching ACK_TMO: same as ack, except the RD response dat=32'hDEAD_DEAD.
- ST_REL: wait until nic_ack==0 (at least 1 clock); then ST_IDLE if the response buffer is empty, else ST_RESP.
- ST_RESP: wait for response injection, then ST_IDLE.
- Incoming RACK with did==id:
  - rx_valid==0: capture into rx_pkt, rx_valid←1 (slot freed).
  - rx_valid==1: forward.
  - rx_ack clears rx_valid.
  - rx_ack and a capture in the same cycle: capture wins, rx_valid stays 1 with new data.
- Forwarded packets get age+1.
- Drop instead of forward (drop_cnt+1, saturate at 8'hFF) when:
  - incoming age==MAX_AGE, or
  - sid==id and typ!=RACK (request returned undelivered).
- Output slot priority per cycle:
  1. forwarded packet;
  2. response buffer (slot free: incoming NOP, consumed, captured or dropped);
  3. tx_pkt if tx_req (tx_ack=1 that cycle, age forced 0);
  4. NOP.
- Ring latency: exactly 1 clock per node.

Optional Feature:
- Macro: RF68000_NIC_BROADCAST_EN.
- Defined: WR with did==4'hF is executed locally when state==ST_IDLE and is also forwarded (age+1). It is removed only when sid==id, and that removal does not count as a drop. If busy, it is forwarded without local execution.
- Undefined: did==4'hF is treated as an ordinary non-matching id.

Decomposition:
- Package rf68000_nic_pkg: PKT_W, packet_t packed struct, pkt_typ_t enum (NOP/WR/RD/RACK), nic_state_t enum (ST_IDLE/ST_BUS/ST_REL/ST_RESP), BCAST_ID=4'hF.
- One sub-module, rf68000_nic_slot_mux: combinational output-slot priority select plus age/drop decision.

Test Plan:
- WR did=id, adr=FFF0_0010 (id=0), dat=1234_5678, sel=F → nic_cyc/stb/we high next clock with those values; ack after 3 clocks → cyc drops; no response packet.
- RD did=id sid=2 adr=FFF0_0020, nic_dati=CAFE_BABE → packet_o carries {RACK, did=2, sid=id, dat=CAFE_BABE} in the first free slot after nic_ack falls.
- RD while ST_BUS → forwarded with age+1 one clock later; packet with age=15 → NOP out, drop_cnt=1.
- tx_req held with a continuous non-NOP, non-local stream → tx_ack stays 0; first NOP input slot → tx_ack=1 and packet_o=tx_pkt with age=0.
- nic_ack never asserted on RD → cyc drops after 255 clocks; response dat=DEAD_DEAD.
- Two RACKs to id without rx_ack → first captured, second forwarded with age+1; rst_ni low during ST_BUS → nic_cyc=0 and rx_valid=0 next edge.
